// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: control schedule for a time-multiplexed FIR datapath.
// Accepts one sample per handshake, steps a shared MAC unit through all taps,
// waits out the MAC pipeline latency and presents the result via valid/ready.
// The delay line is zero-flushed after reset and on request from IDLE.
module fir_mac_sequencer #(
    parameter int NTAPS   = 16,
    parameter int ADDR_W  = 4,
    parameter int MAC_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic              wr_en_o,
    output logic              wr_zero_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [ADDR_W-1:0] coef_addr_o,
    output logic              mac_en_o,
    output logic              mac_clr_o,
    output logic              mac_last_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FLUSH = 3'd1,
        S_IDLE  = 3'd2,
        S_MAC   = 3'd3,
        S_DRAIN = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    // Last value of the tap/step counter, and last drain step.
    localparam logic [ADDR_W:0]   K_LAST    = (ADDR_W+1)'(NTAPS - 1);
    localparam logic [2:0]        D_LAST    = 3'(MAC_LAT - 1);
    localparam logic [ADDR_W-1:0] HEAD_INIT = ADDR_W'(NTAPS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   head_q, head_d;
    logic [ADDR_W:0]     k_q, k_d;
    logic [2:0]          drain_q, drain_d;
    logic [ADDR_W-1:0]   k_addr;

    assign k_addr = k_q[ADDR_W-1:0];

    // State, newest-sample pointer and counters; reset discards any work in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_INIT;
            head_q  <= HEAD_INIT;
            k_q     <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            k_q     <= k_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic and output decode; everything defaults to idle/zero.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        k_d         = k_q;
        drain_d     = drain_q;
        in_ready_o  = 1'b0;
        wr_en_o     = 1'b0;
        wr_zero_o   = 1'b0;
        wr_addr_o   = '0;
        rd_addr_o   = '0;
        coef_addr_o = '0;
        mac_en_o    = 1'b0;
        mac_clr_o   = 1'b0;
        mac_last_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;

        case (state_q)
            S_INIT: begin
                head_d  = HEAD_INIT;
                k_d     = '0;
                state_d = S_FLUSH;
            end

            S_FLUSH: begin
                busy_o    = 1'b1;
                wr_en_o   = 1'b1;
                wr_zero_o = 1'b1;
                wr_addr_o = k_addr;
                if (k_q == K_LAST) begin
                    head_d  = HEAD_INIT;
                    state_d = S_IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S_IDLE: begin
                // A pending flush blocks acceptance so no sample is lost to it.
                in_ready_o = ~flush_i;
                if (flush_i) begin
                    k_d     = '0;
                    state_d = S_FLUSH;
                end else if (in_valid_i) begin
                    wr_en_o   = 1'b1;
                    wr_addr_o = head_q + 1'b1;
                    head_d    = head_q + 1'b1;
                    k_d       = '0;
                    state_d   = S_MAC;
                end
            end

            S_MAC: begin
                busy_o      = 1'b1;
                mac_en_o    = 1'b1;
                coef_addr_o = k_addr;
                rd_addr_o   = head_q - k_addr;
                mac_clr_o   = (k_q == '0);
                mac_last_o  = (k_q == K_LAST);
                if (k_q == K_LAST) begin
                    drain_d = '0;
                    state_d = (MAC_LAT == 0) ? S_HOLD : S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S_DRAIN: begin
                // Let the last product propagate into the accumulator.
                busy_o = 1'b1;
                if (drain_q == D_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end

            S_HOLD: begin
                busy_o      = 1'b1;
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Testbench for fir_mac_sequencer at default parameters (16 taps, MAC latency 2).
// Accepted samples go into a scoreboard queue; a monitor checks each MAC pass
// and the result presentation against the queued expectation.
module tb_fir_mac_sequencer;

    localparam int NTAPS   = 16;
    localparam int ADDR_W  = 4;
    localparam int MAC_LAT = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, flush;
    logic              wr_en, wr_zero;
    logic [ADDR_W-1:0] wr_addr, rd_addr, coef_addr;
    logic              mac_en, mac_clr, mac_last;
    logic              out_valid, out_ready, busy;

    fir_mac_sequencer #(.NTAPS(NTAPS), .ADDR_W(ADDR_W), .MAC_LAT(MAC_LAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .flush_i     (flush),
        .wr_en_o     (wr_en),
        .wr_zero_o   (wr_zero),
        .wr_addr_o   (wr_addr),
        .rd_addr_o   (rd_addr),
        .coef_addr_o (coef_addr),
        .mac_en_o    (mac_en),
        .mac_clr_o   (mac_clr),
        .mac_last_o  (mac_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ADDR_W-1:0] head;
        int                acc;
    } job_t;

    job_t              sb[$];
    logic [ADDR_W-1:0] head_m;
    int                n_chk = 0;
    int                n_err = 0;

    logic [19:0] all_outs;
    assign all_outs = {in_ready, wr_en, wr_zero, wr_addr, rd_addr, coef_addr,
                       mac_en, mac_clr, mac_last, out_valid, busy};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: checks every MAC step and the result timing against the scoreboard.
    int   mon_tap = 0;
    logic [ADDR_W-1:0] mon_head = '0;
    logic prev_ov = 1'b0;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            mon_tap = 0;
            prev_ov = 1'b0;
        end else begin
            if (sb.size() == 0) begin
                chk("ov_nojob", 32'(out_valid), 0);
            end
            if (mac_en) begin
                if (mon_tap == 0) begin
                    if (sb.size() == 0) chk("mac_nojob", 0, 1);
                    else mon_head = sb[0].head;
                end
                chk("coef_addr", 32'(coef_addr), 32'(mon_tap));
                chk("rd_addr", 32'(rd_addr), 32'(4'(mon_head - 4'(mon_tap))));
                chk("mac_clr", 32'(mac_clr), 32'(mon_tap == 0));
                chk("mac_last", 32'(mac_last), 32'(mon_tap == NTAPS - 1));
                if (mon_tap == NTAPS - 1 && sb.size() != 0)
                    chk("last_lat", cyc - sb[0].acc, NTAPS);
                mon_tap = (mon_tap == NTAPS - 1) ? 0 : mon_tap + 1;
            end
            if (out_valid && !prev_ov && sb.size() != 0) begin
                chk("ov_lat", cyc - sb[0].acc, NTAPS + MAC_LAT + 1);
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                void'(sb.pop_front());
            end
            prev_ov = out_valid;
        end
    end

    // Sixteen zero-writes to ascending addresses, inputs held low.
    task automatic flush_run();
        for (int i = 0; i < NTAPS; i++) begin
            @(negedge clk);
            flush    = 1'b0;
            in_valid = 1'b0;
            #2;
            chk("fl_wr_en", 32'(wr_en), 1);
            chk("fl_wr_zero", 32'(wr_zero), 1);
            chk("fl_wr_addr", 32'(wr_addr), i);
            chk("fl_in_ready", 32'(in_ready), 0);
            chk("fl_mac_en", 32'(mac_en), 0);
        end
        @(negedge clk);
        #2;
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_busy", 32'(busy), 0);
        head_m = 4'hF;
    endtask

    task automatic release_check();
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        chk("init_outs", 32'(all_outs), 0);
        flush_run();
    endtask

    task automatic send_sample(output int acc);
        int n;
        logic [ADDR_W-1:0] nh;
        n   = 0;
        acc = -1;
        @(negedge clk);
        in_valid = 1'b1;
        #2;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            nh = head_m + 4'd1;
            chk("smp_wr_en", 32'(wr_en), 1);
            chk("smp_wr_zero", 32'(wr_zero), 0);
            chk("smp_wr_addr", 32'(wr_addr), 32'(nh));
            head_m = nh;
            acc    = cyc;
            sb.push_back('{head: nh, acc: cyc});
            $display("sample accepted: wr_addr=%0d cycle=%0d", nh, cyc);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int a, prev, n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        head_m    = 4'hF;

        // Reset state, then full INIT + flush after release.
        repeat (3) @(negedge clk);
        #2;
        chk("rst_outs", 32'(all_outs), 0);
        release_check();

        // Single sample into a freshly flushed delay line.
        send_sample(a);
        wait_done();

        // Back-to-back samples with source and sink always ready.
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            send_sample(a);
            if (i > 0) chk("period", a - prev, NTAPS + MAC_LAT + 2);
            prev = a;
        end
        wait_done();

        // Sink stalls for 10 cycles in HOLD.
        out_ready = 1'b0;
        send_sample(a);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        #2;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("hold_reached", 32'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #2;
            end
            chk("hold_ov", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_mac_en", 32'(mac_en), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #2;
        chk("hs_ov", 32'(out_valid), 1);
        @(negedge clk);
        #2;
        chk("post_hs_ov", 32'(out_valid), 0);
        chk("post_hs_in_ready", 32'(in_ready), 1);

        // Flush wins over a simultaneous sample.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        #2;
        chk("flush_in_ready", 32'(in_ready), 0);
        chk("flush_no_write", 32'(wr_en), 0);
        flush_run();
        send_sample(a);
        chk("after_flush_addr", 32'(head_m), 0);
        wait_done();

        // Reset in the middle of MAC discards the result and re-runs the flush.
        send_sample(a);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2;
        chk("pre_rst_k", 32'(coef_addr), 7);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("async_rst_outs", 32'(all_outs), 0);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_hold_outs", 32'(all_outs), 0);
        release_check();
        repeat (25) @(negedge clk);
        #2;
        chk("no_stale_ov", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
